ir_nec_decode: RTL and testbench

Downstream stage of the IR receiver. It takes each 32-bit NEC frame the receiver latches and checks the address and command complement bytes. Good frames become {address, command, extended, repeat} entries in a small FIFO, drained over a valid/ready handshake by the command consumer (UART bridge, LED/motor control). Bad and dropped frames are counted and flagged.

---
 rtl/ir_pkg.sv | 32 +++
 rtl/ir_nec_decode_if.sv | 19 +
 rtl/ir_cmd_fifo.sv | 50 +++++
 rtl/ir_nec_decode.sv | 156 +++++++++++++++
 tb/tb_ir_nec_decode.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared IR receive-path constants: clock rate, NEC frame layout, decoded entry layout
// and protocol timing expressed in clock cycles.
package ir_pkg;

  localparam int unsigned F_CLK = 100_000_000;

  // NEC frame byte offsets (LSB = first bit received).
  localparam int unsigned NEC_ADDR_OFS   = 0;
  localparam int unsigned NEC_ADDR_N_OFS = 8;
  localparam int unsigned NEC_CMD_OFS    = 16;
  localparam int unsigned NEC_CMD_N_OFS  = 24;

  localparam int unsigned ENTRY_W = 26;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        ext;
    logic        rpt;
  } ir_entry_t;

  localparam int unsigned CYC_PER_US          = F_CLK / 1_000_000;
  localparam int unsigned NEC_LEADER_CYCLES   = 9000 * CYC_PER_US;
  localparam int unsigned NEC_SPACE_CYCLES    = 4500 * CYC_PER_US;
  localparam int unsigned NEC_BIT_UNIT_CYCLES = 562 * CYC_PER_US;
  localparam int unsigned NEC_HOLD_CYCLES     = 110_000 * CYC_PER_US;

  function automatic logic [7:0] nec_field(input logic [31:0] frame, input int unsigned ofs);
    return frame[ofs +: 8];
  endfunction

endpackage

// File: rtl/ir_nec_decode_if.sv
// Decoded-command stream from ir_nec_decode to its consumer (valid/ready).
interface ir_nec_decode_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [7:0]  out_cmd;
  logic        out_ext;
  logic        out_repeat;

  modport master (
    output out_valid, out_addr, out_cmd, out_ext, out_repeat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_cmd, out_ext, out_repeat,
    output out_ready
  );
endinterface

// File: rtl/ir_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is the oldest entry, registered storage.
module ir_cmd_fifo #(
  parameter int unsigned Width = 26,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic             wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + PW'(1);
    if (rd_en) rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ir_nec_decode.sv
// NEC frame checker: validates complement bytes, tags repeats, queues good commands,
// and counts rejected / dropped frames.
module ir_nec_decode
  import ir_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = NEC_HOLD_CYCLES,
  parameter bit          EXT_ADDR_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            frame,
  input  logic                   frame_valid,
  ir_nec_decode_if.master        out_if,
  output logic [7:0]             err_cnt,
  output logic                   overflow,
  input  logic                   clr_err
);

  localparam logic [31:0] HoldLim = 32'(HOLD_CYCLES);

  logic [31:0] frame_q;
  logic        fvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      fvalid_q <= frame_valid;
      if (frame_valid) frame_q <= frame;
    end
  end

  logic [7:0]  a, an, c, cn;
  logic        good, bad, ext;
  logic [15:0] addr;

  assign a  = nec_field(frame_q, NEC_ADDR_OFS);
  assign an = nec_field(frame_q, NEC_ADDR_N_OFS);
  assign c  = nec_field(frame_q, NEC_CMD_OFS);
  assign cn = nec_field(frame_q, NEC_CMD_N_OFS);

  always_comb begin
    good = 1'b0;
    bad  = 1'b0;
    ext  = 1'b0;
    addr = {8'h00, a};
    if (fvalid_q) begin
      if (cn != ~c) begin
        bad = 1'b1;
      end else if (an == ~a) begin
        good = 1'b1;
      end else if (EXT_ADDR_EN) begin
        good = 1'b1;
        ext  = 1'b1;
        addr = {an, a};
      end else begin
        bad = 1'b1;
      end
    end
  end

  // Repeat tracking against the most recent good frame, dropped or not.
  logic [15:0] last_addr_q, last_addr_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic        last_ok_q, last_ok_d;
  logic [31:0] hold_tim_q, hold_tim_d;
  logic        rpt;

  assign rpt = last_ok_q && (addr == last_addr_q) && (c == last_cmd_q) && (hold_tim_q < HoldLim);

  always_comb begin
    last_addr_d = last_addr_q;
    last_cmd_d  = last_cmd_q;
    last_ok_d   = last_ok_q;
    hold_tim_d  = (hold_tim_q < HoldLim) ? hold_tim_q + 32'd1 : hold_tim_q;
    if (good) begin
      last_addr_d = addr;
      last_cmd_d  = c;
      last_ok_d   = 1'b1;
      hold_tim_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr_q <= '0;
      last_cmd_q  <= '0;
      last_ok_q   <= 1'b0;
      hold_tim_q  <= HoldLim;
    end else begin
      last_addr_q <= last_addr_d;
      last_cmd_q  <= last_cmd_d;
      last_ok_q   <= last_ok_d;
      hold_tim_q  <= hold_tim_d;
    end
  end

  ir_entry_t            new_entry, head_entry;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_full, fifo_empty, pop;

  assign new_entry = '{addr: addr, cmd: c, ext: ext, rpt: rpt};
  assign pop       = out_if.out_valid & out_if.out_ready;

  ir_cmd_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (good),
    .pop_i   (pop),
    .data_i  (new_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  assign head_entry        = head_raw;
  assign out_if.out_valid  = ~fifo_empty;
  assign out_if.out_addr   = head_entry.addr;
  assign out_if.out_cmd    = head_entry.cmd;
  assign out_if.out_ext    = head_entry.ext;
  assign out_if.out_repeat = head_entry.rpt;

  logic [7:0] err_cnt_q, err_cnt_d;
  logic       overflow_q, overflow_d;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    overflow_d = overflow_q;
    if (clr_err) begin
      err_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (good && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ir_nec_decode.sv
// Bench for ir_nec_decode: table of frames with expected fields, a scoreboard of
// queued entries checked as they drain, and hand sequences for timing corners.
module tb_ir_nec_decode;
  import ir_pkg::*;

  localparam int HOLD  = 1000;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] frame;
    logic        good;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        ext;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame;
  logic        frame_valid;
  logic        clr_err;
  logic [7:0]  err_cnt, err_cnt_n;
  logic        overflow, overflow_n;

  ir_nec_decode_if out_if ();
  ir_nec_decode_if out_if_n ();

  ir_nec_decode #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .EXT_ADDR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .out_if(out_if),
    .err_cnt(err_cnt), .overflow(overflow), .clr_err(clr_err)
  );

  ir_nec_decode #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .EXT_ADDR_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .out_if(out_if_n),
    .err_cnt(err_cnt_n), .overflow(overflow_n), .clr_err(clr_err)
  );

  assign out_if_n.out_ready = 1'b1;

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          cyc = 0;
  ir_entry_t   sb[$];
  int          m_err = 0, m_err_n = 0;
  logic        m_last_ok = 1'b0;
  logic [15:0] m_last_a;
  logic [7:0]  m_last_c;
  int          m_last_cyc = 0;
  ir_entry_t   e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // hold_tim is zeroed one edge after the previous good strobe, so the window is gap-1.
  function automatic logic calc_rpt(input logic [15:0] a, input logic [7:0] c);
    return m_last_ok && (a == m_last_a) && (c == m_last_c) && ((cyc - m_last_cyc - 1) < HOLD);
  endfunction

  task automatic note_good(input logic [15:0] a, input logic [7:0] c);
    m_last_ok  = 1'b1;
    m_last_a   = a;
    m_last_c   = c;
    m_last_cyc = cyc;
  endtask

  task automatic send(input logic [31:0] f, input logic good, input logic [15:0] a,
                      input logic [7:0] c, input logic ext);
    ir_entry_t e;
    frame = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    if (good) begin
      e = '{addr: a, cmd: c, ext: ext, rpt: calc_rpt(a, c)};
      note_good(a, c);
      if (sb.size() < DEPTH) sb.push_back(e);
    end else if (m_err != 255) begin
      m_err++;
    end
    if ((!good || ext) && m_err_n != 255) m_err_n++;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err = 0;
    m_err_n = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_if.out_valid && out_if.out_ready) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_entry: got 0x%0h, expected none", {out_if.out_addr,
                 out_if.out_cmd, out_if.out_ext, out_if.out_repeat});
      end else begin
        e_mon = sb.pop_front();
        chk("head_entry", {out_if.out_addr, out_if.out_cmd, out_if.out_ext, out_if.out_repeat},
            e_mon);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [7:0]  c;
    ir_entry_t   e;

    vecs[0] = '{32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0};
    vecs[1] = '{32'h0008FB04, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[2] = '{32'hF7081234, 1'b1, 16'h1234, 8'h08, 1'b1};
    vecs[3] = '{32'hEF10BF40, 1'b1, 16'h0040, 8'h10, 1'b0};
    vecs[4] = '{32'h00FF00FF, 1'b1, 16'h00FF, 8'hFF, 1'b0};
    vecs[5] = '{32'hFF00FF00, 1'b1, 16'h0000, 8'h00, 1'b0};
    vecs[6] = '{32'hF8071234, 1'b1, 16'h1234, 8'h07, 1'b1};
    vecs[7] = '{32'h12345678, 1'b0, 16'h0000, 8'h00, 1'b0};

    rst = 1'b0;
    frame = '0;
    frame_valid = 1'b0;
    clr_err = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_if.out_valid, 0);
    chk("rst_out_addr", out_if.out_addr, 0);
    chk("rst_out_cmd", out_if.out_cmd, 0);
    chk("rst_out_ext", out_if.out_ext, 0);
    chk("rst_out_repeat", out_if.out_repeat, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    // Two-edge latency for a standard frame into an empty FIFO, popped on the next edge.
    out_if.out_ready = 1'b1;
    send(32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0);
    chk("lat_valid_e0", out_if.out_valid, 0);
    tick();
    chk("lat_valid_e1", out_if.out_valid, 1);
    chk("lat_addr", out_if.out_addr, 16'h0004);
    chk("lat_cmd", out_if.out_cmd, 8'h08);
    chk("lat_ext", out_if.out_ext, 0);
    chk("lat_repeat", out_if.out_repeat, 0);
    tick();
    chk("lat_popped", out_if.out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].frame, vecs[i].good, vecs[i].addr, vecs[i].cmd, vecs[i].ext);
      repeat (5) tick();
    end
    drain();
    chk("tbl_err_cnt", err_cnt, m_err);
    chk("tbl_err_cnt_noext", err_cnt_n, m_err_n);
    chk("tbl_overflow", overflow, 0);

    // Error counter: latency, saturation, clear.
    pulse_clr();
    send(32'h0008FB04, 1'b0, 16'h0, 8'h0, 1'b0);
    chk("err_e0", err_cnt, 0);
    tick();
    chk("err_one", err_cnt, 1);
    chk("err_no_push", out_if.out_valid, 0);
    for (int i = 0; i < 299; i++) send(32'h0008FB04, 1'b0, 16'h0, 8'h0, 1'b0);
    tick();
    chk("err_sat", err_cnt, 255);
    chk("err_sat_noext", err_cnt_n, 255);
    pulse_clr();
    chk("err_clr", err_cnt, 0);
    chk("err_clr_noext", err_cnt_n, 0);

    // Repeat window: 500 cycles apart repeats, 1001 later does not.
    send(32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0);
    repeat (499) tick();
    send(32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0);
    tick();
    chk("rpt_in_window", out_if.out_repeat, 1);
    repeat (999) tick();
    send(32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0);
    tick();
    chk("rpt_expired", out_if.out_repeat, 0);
    drain();

    // Overflow: five frames into a four-deep FIFO with the consumer stalled.
    out_if.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      c = 8'(i);
      send({~c, c, 8'hFB, 8'h04}, 1'b1, 16'h0004, c, 1'b0);
    end
    tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", out_if.out_valid, 1);
    chk("ovf_head_cmd", out_if.out_cmd, 8'h01);
    pulse_clr();
    chk("ovf_clr", overflow, 0);

    // Full FIFO: push and pop on the same edge keeps the count and raises no overflow.
    c = 8'h06;
    frame = {~c, c, 8'hFB, 8'h04};
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    out_if.out_ready = 1'b1;
    e = '{addr: 16'h0004, cmd: c, ext: 1'b0, rpt: calc_rpt(16'h0004, c)};
    note_good(16'h0004, c);
    sb.push_back(e);
    tick();
    out_if.out_ready = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    chk("pp_valid", out_if.out_valid, 1);
    out_if.out_ready = 1'b1;
    repeat (4) tick();
    chk("pp_count4", out_if.out_valid, 0);
    chk("pp_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-drain.
    out_if.out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      c = 8'(i);
      send({~c, c, 8'hFB, 8'h04}, 1'b1, 16'h0004, c, 1'b0);
    end
    tick();
    out_if.out_ready = 1'b1;
    tick();
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", out_if.out_valid, 0);
    chk("arst_addr", out_if.out_addr, 0);
    chk("arst_cmd", out_if.out_cmd, 0);
    sb.delete();
    m_last_ok = 1'b0;
    m_err = 0;
    m_err_n = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_still_empty", out_if.out_valid, 0);
    send(32'hF708FB04, 1'b1, 16'h0004, 8'h08, 1'b0);
    tick();
    chk("arst_first_valid", out_if.out_valid, 1);
    chk("arst_first_repeat", out_if.out_repeat, 0);
    drain();
    chk("end_err_cnt", err_cnt, m_err);
    chk("end_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
